fifo_display: RTL and testbench

- Downstream consumer of the 4-bit FIFO top: captures each value popped from the FIFO and shows it on a 4-digit multiplexed seven-segment display.
- Digits 0-2 hold the last three read values, newest on the right. Digit 3 shows a single status character derived from the FIFO flags.
- Sits between the FIFO top and the board display pins; all outputs are registered.

---
 rtl/fifo_disp_pkg.sv | 46 ++++
 rtl/fifo_display_seg7_decoder.sv | 26 ++
 rtl/fifo_display.sv | 132 +++++++++++++
 tb/tb_fifo_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_disp_pkg.sv
// Shared constants, glyph select type and hex glyph helper
// for the FIFO seven-segment readout.
package fifo_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int HIST_DEPTH = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_T     = 7'b0000111;

  typedef enum logic [2:0] {
    SEL_HEX,
    SEL_R,
    SEL_F,
    SEL_E,
    SEL_T
  } glyph_sel_e;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fifo_display_seg7_decoder.sv
// Combinational glyph selector: hex digit, status letter
// or blank.
module seg7_decoder
  import fifo_disp_pkg::*;
(
  input  logic       [3:0] val_i,
  input  logic             blank_i,
  input  glyph_sel_e       sel_i,
  output logic       [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (sel_i)
        SEL_HEX: seg_o = hex_to_seg(val_i);
        SEL_R:   seg_o = SEG_R;
        SEL_F:   seg_o = SEG_F;
        SEL_E:   seg_o = SEG_E;
        SEL_T:   seg_o = SEG_T;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fifo_display.sv
// Read-history and FIFO status readout on a 4-digit mux display.
// FIFO_DISP_BLINK_ERROR_EN: blink the whole display while error=1.
module fifo_display
  import fifo_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int BLINK_BITS   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       rd_valid,
  input  logic [3:0] data_out,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       fifo_threshold,
  input  logic       error,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              idx;

  logic [3:0]            hist_q [HIST_DEPTH];
  logic [3:0]            hist_d [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid_q, valid_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  glyph_sel_e sel;
  logic       blank;
  logic [3:0] val;
  logic       dark;

  assign cnt_d = cnt_q + REFRESH_BITS'(1);
  assign idx   = cnt_q[REFRESH_BITS-1 -: 2];

  // Clear is applied before the capture so both can share a cycle
  always_comb begin
    hist_d  = hist_q;
    valid_d = valid_q;
    if (clr) begin
      hist_d  = '{default: '0};
      valid_d = '0;
    end
    if (rd_valid) begin
      hist_d[2] = hist_d[1];
      hist_d[1] = hist_d[0];
      hist_d[0] = data_out;
      valid_d   = {valid_d[1:0], 1'b1};
    end
  end

  always_comb begin
    sel   = SEL_HEX;
    blank = 1'b1;
    val   = 4'h0;
    unique case (idx)
      2'd0: begin
        val   = hist_q[0];
        blank = ~valid_q[0];
      end
      2'd1: begin
        val   = hist_q[1];
        blank = ~valid_q[1];
      end
      2'd2: begin
        val   = hist_q[2];
        blank = ~valid_q[2];
      end
      2'd3: begin
        blank = 1'b0;
        if (error)               sel = SEL_R;
        else if (fifo_full)      sel = SEL_F;
        else if (fifo_empty)     sel = SEL_E;
        else if (fifo_threshold) sel = SEL_T;
        else                     blank = 1'b1;
      end
    endcase
  end

  seg7_decoder u_dec (
    .val_i   (val),
    .blank_i (blank),
    .sel_i   (sel),
    .seg_o   (seg_d)
  );

`ifdef FIFO_DISP_BLINK_ERROR_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_q <= '0;
    else      blink_q <= blink_q + BLINK_BITS'(1);
  end

  assign dark = error & blink_q[BLINK_BITS-1];
`else
  assign dark = 1'b0;

  // Blink width is meaningless without the blink counter
  if (BLINK_BITS < 1) begin : g_no_blink
  end
`endif

  always_comb begin
    an_d = ~(NUM_DIGITS'(1) << idx);
    if (dark) an_d = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      hist_q  <= '{default: '0};
      valid_q <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_fifo_display.sv
// Directed scoreboard bench for fifo_display (REFRESH_BITS=4).
// Expected digit frames come from a local history/flag model.
module tb_fifo_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       rd_valid = 1'b0;
  logic [3:0] data_out = 4'h0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       fifo_threshold = 1'b0;
  logic       error = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_display #(
    .REFRESH_BITS (4),
    .BLINK_BITS   (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .rd_valid       (rd_valid),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .error          (error),
    .an             (an),
    .seg            (seg)
  );

  localparam logic [6:0] BLK = 7'b1111111;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0] m_hist [3] = '{4'h0, 4'h0, 4'h0};
  logic [2:0] m_valid = 3'b000;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [10:0] obs,
                       input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] m_status();
    if (error)          return 7'b0101111;
    if (fifo_full)      return 7'b0001110;
    if (fifo_empty)     return 7'b0000110;
    if (fifo_threshold) return 7'b0000111;
    return BLK;
  endfunction

  task automatic push_frame(input string tag);
    exp_t e;
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 4'b0001 << i;
      e.tag = $sformatf("%s_d%0d", tag, i);
      e.an  = ~a;
      if (i == 3)          e.seg = m_status();
      else if (m_valid[i]) e.seg = glyph[m_hist[i]];
      else                 e.seg = BLK;
      sb.push_back(e);
    end
  endtask

  task automatic wait_an(input logic [3:0] v, input bit eq);
    for (int k = 0; k < 200 && ((an === v) != eq); k++)
      @(negedge clk);
  endtask

  task automatic drain();
    exp_t e;
    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_an(e.an, 1'b1);
      check(e.tag, {an, seg}, {e.an, e.seg});
    end
  endtask

  task automatic capture(input logic [3:0] d);
    rd_valid = 1'b1;
    data_out = d;
    @(negedge clk);
    rd_valid = 1'b0;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = d;
    m_valid   = {m_valid[1:0], 1'b1};
  endtask

  int dark_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", {7'd0, an}, {7'd0, 4'b1111});
    check("rst_seg", {4'd0, seg}, {4'd0, BLK});
    rst = 1'b1;

    @(negedge clk);
    check("scan_0", {7'd0, an}, {7'd0, 4'b1110});
    repeat (4) @(negedge clk);
    check("scan_1", {7'd0, an}, {7'd0, 4'b1101});
    repeat (4) @(negedge clk);
    check("scan_2", {7'd0, an}, {7'd0, 4'b1011});
    repeat (4) @(negedge clk);
    check("scan_3", {7'd0, an}, {7'd0, 4'b0111});
    repeat (4) @(negedge clk);
    check("scan_wrap", {7'd0, an}, {7'd0, 4'b1110});

    push_frame("idle");
    drain();

    capture(4'h3);
    capture(4'h7);
    capture(4'hA);
    capture(4'h5);
    push_frame("hist");
    drain();

    error = 1'b1;
    fifo_full = 1'b1;
    push_frame("err_full");
    drain();

    wait_an(4'b0111, 1'b0);
    wait_an(4'b0111, 1'b1);
    check("lat_before", {4'd0, seg}, {4'd0, 7'b0101111});
    error = 1'b0;
    fifo_empty = 1'b1;
    @(negedge clk);
    check("lat_after", {4'd0, seg}, {4'd0, 7'b0001110});
    push_frame("full_empty");
    drain();

    fifo_full = 1'b0;
    fifo_threshold = 1'b1;
    push_frame("empty_thr");
    drain();

    fifo_empty = 1'b0;
    push_frame("thr");
    drain();

    fifo_threshold = 1'b0;
    clr = 1'b1;
    rd_valid = 1'b1;
    data_out = 4'h9;
    @(negedge clk);
    clr = 1'b0;
    rd_valid = 1'b0;
    m_hist  = '{4'h9, 4'h0, 4'h0};
    m_valid = 3'b001;
    push_frame("clr_cap");
    drain();

    capture(4'hC);
    wait_an(4'b1101, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("async_an", {7'd0, an}, {7'd0, 4'b1111});
    check("async_seg", {4'd0, seg}, {4'd0, BLK});
    @(negedge clk);
    rst = 1'b1;
    m_hist  = '{4'h0, 4'h0, 4'h0};
    m_valid = 3'b000;
    push_frame("post_rst");
    drain();

    error = 1'b1;
    repeat (2) @(negedge clk);
    dark_cnt = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (an === 4'b1111) dark_cnt++;
    end
`ifdef FIFO_DISP_BLINK_ERROR_EN
    check("blink_dark", 11'(dark_cnt), 11'd64);
`else
    check("no_blink", 11'(dark_cnt), 11'd0);
`endif
    error = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
